// File: rtl/sock_package_dispatcher_pkg.sv
// Shared definitions for the sock package dispatcher: package codes, source
// count, dispatcher states and round-robin index helpers.
package sock_pkg_defs;

  localparam int NUM_SRC = 5;

  localparam logic [2:0] PKG_NONE     = 3'd0;
  localparam logic [2:0] PKG_ALG_BAJO = 3'd1;
  localparam logic [2:0] PKG_POL_BAJO = 3'd2;
  localparam logic [2:0] PKG_ACR_BAJO = 3'd3;
  localparam logic [2:0] PKG_ALG_ALTO = 3'd4;
  localparam logic [2:0] PKG_ACR_ALTO = 3'd5;

  typedef enum logic {
    LOAD   = 1'b0,
    DEPART = 1'b1
  } dispatchState_t;

  // Source index reached by stepping k places from base, wrapping 4 -> 0.
  function automatic logic [2:0] srcAt(input logic [2:0] base, input int k);
    return 3'((int'(base) + k) % NUM_SRC);
  endfunction

  function automatic logic [2:0] nextSrc(input logic [2:0] g);
    return (g == 3'(NUM_SRC - 1)) ? 3'd0 : g + 3'd1;
  endfunction

endpackage

// File: rtl/sock_package_dispatcher_fifo.sv
// Parameterised synchronous FIFO holding package codes between the arbiter
// and the truck loader; push and pop may coincide when not empty.
module sock_pkg_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 3,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty,
  output logic [AW:0]      o_level
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [AW:0]      r_level;
  logic             w_doPush;
  logic             w_doPop;

  assign o_full   = (r_level == (AW+1)'(DEPTH));
  assign o_empty  = (r_level == '0);
  assign o_level  = r_level;
  assign o_head   = r_mem[r_rdPtr];
  assign w_doPush = i_push && !o_full;
  assign w_doPop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_level <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
      if (w_doPush && !w_doPop)      r_level <= r_level + 1'b1;
      else if (!w_doPush && w_doPop) r_level <= r_level - 1'b1;
    end
  end

  // Storage needs no reset: entries are only read once the level covers them.
  always_ff @(posedge clk) begin
    if (reset && w_doPush) r_mem[r_wrPtr] <= i_data;
  end

endmodule

// File: rtl/sock_package_dispatcher.sv
// Collects package-complete pulses from the five sock counters, arbitrates them
// round-robin into a FIFO and hands packages to the truck loader, one truck at a time.
module sock_package_dispatcher
  import sock_pkg_defs::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TRUCK_CAP  = 6
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [4:0]                  co,
  input  logic                        pkg_ready,
  input  logic                        truck_depart,
  output logic                        pkg_valid,
  output logic [2:0]                  pkg_code,
  output logic [3:0]                  truck_count,
  output logic                        truck_full,
  output logic [4:0]                  lost,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam logic [3:0] CAP = 4'(TRUCK_CAP);

  logic [4:0]     r_pending;
  logic [2:0]     r_rrPtr;
  logic [4:0]     r_lost;
  dispatchState_t r_state;
  logic [3:0]     r_truckCount;

  logic [4:0] w_grant;
  logic [2:0] w_grantIdx;
  logic       w_grantAny;
  logic       w_fifoFull;
  logic       w_fifoEmpty;
  logic [2:0] w_head;
  logic       w_transfer;

  // First pending source at or after the round-robin pointer, only while the FIFO has room.
  always_comb begin
    w_grantAny = 1'b0;
    w_grantIdx = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (!w_grantAny && !w_fifoFull && r_pending[srcAt(r_rrPtr, k)]) begin
        w_grantAny = 1'b1;
        w_grantIdx = srcAt(r_rrPtr, k);
      end
    end
    w_grant = w_grantAny ? (5'b00001 << w_grantIdx) : 5'b00000;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pending <= '0;
      r_rrPtr   <= '0;
      r_lost    <= '0;
    end else begin
      r_pending <= (r_pending & ~w_grant) | co;
      r_lost    <= r_lost | (co & r_pending & ~w_grant);
      if (w_grantAny) r_rrPtr <= nextSrc(w_grantIdx);
    end
  end

  sock_pkg_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (3)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_grantAny),
    .i_pop   (w_transfer),
    .i_data  (w_grantIdx + 3'd1),
    .o_head  (w_head),
    .o_full  (w_fifoFull),
    .o_empty (w_fifoEmpty),
    .o_level (fifo_level)
  );

  assign pkg_valid   = (r_state == LOAD) && !w_fifoEmpty;
  assign pkg_code    = pkg_valid ? w_head : PKG_NONE;
  assign w_transfer  = pkg_valid && pkg_ready;
  assign truck_count = r_truckCount;
  assign truck_full  = (r_state == DEPART);
  assign lost        = r_lost;

  // The transfer that fills the truck also switches to DEPART, so issue stops immediately.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= LOAD;
      r_truckCount <= '0;
    end else begin
      case (r_state)
        LOAD: begin
          if (w_transfer && r_truckCount != CAP) begin
            r_truckCount <= r_truckCount + 4'd1;
            if (r_truckCount + 4'd1 == CAP) r_state <= DEPART;
          end
        end
        DEPART: begin
          if (truck_depart) begin
            r_truckCount <= '0;
            r_state      <= LOAD;
          end
        end
        default: r_state <= LOAD;
      endcase
    end
  end

endmodule

// File: doc/sock_package_dispatcher.md
Name: sock_package_dispatcher

Overview:
- Consumer end of the package-counter outputs. It accepts one-cycle "package complete" pulses from the five sock-package counters: algodon/polyester/acrilico bajos and algodon/acrilico altos.
- It arbitrates them round-robin into a small FIFO and presents one package at a time to the truck loader over a valid/ready handshake.
- It tracks truck fill. When the truck holds TRUCK_CAP packages it stops issuing and waits for a depart pulse.
- It sits between the counter bank and the shipping dock in the top-level factory FSM.

Parameters:
- FIFO_DEPTH, 4, package FIFO entries; power of two, at least 2.
- TRUCK_CAP, 6, packages per truck; range 1..15.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  reset, synchronous, active-low; the block resets when reset==0 at a rising clk edge.
- co  in  5  package-complete pulses; bit0 alg_bajo, bit1 pol_bajo, bit2 acr_bajo, bit3 alg_alto, bit4 acr_alto.
- pkg_ready  in  1  loader accepts the current package this cycle.
- truck_depart  in  1  one-cycle pulse; the full truck has left.
- pkg_valid  out  1  pkg_code is valid.
- pkg_code  out  3  package type code; 1..5 = co bit index + 1; 0 = none.
- truck_count  out  4  packages loaded on the current truck.
- truck_full  out  1  truck_count == TRUCK_CAP; the block is in the DEPART state.
- lost  out  5  sticky per-source overflow flags.
- fifo_level  out  3  current FIFO occupancy, 0..FIFO_DEPTH.

Behaviour:
- Reset values: pending=0, rr_ptr=0, FIFO empty, fifo_level=0, pkg_valid=0, pkg_code=0, truck_count=0, truck_full=0, lost=0, state=LOAD.
- Reset mid-handshake discards all queued packages. No partial state survives.
- Capture:
  - pending[i] is set on co[i]=1.
  - If co[i]=1 while pending[i] is already 1 and not being granted this cycle, set lost[i]. The pulse is dropped and pending stays 1.
  - A co[i] arriving in the same cycle pending[i] is granted re-sets pending[i]. It is not lost.
- Arbiter:
  - Each cycle, if FIFO not full and any pending bit is 1, grant the first pending index at or after rr_ptr, wrapping 4->0.
  - The grant clears pending[g], pushes code g+1, and sets rr_ptr=(g+1) mod 5.
  - Capture-to-FIFO latency is 1 cycle. co in cycle n can be at the FIFO head at n+2.
- FIFO:
  - Synchronous FIFO with FIFO_DEPTH entries.
  - Push and pop in the same cycle are allowed when not empty. The level is unchanged.
  - When full, no grant occurs and pending holds the request. This is not a loss.
- Output:
  - pkg_valid = state==LOAD and FIFO not empty.
  - pkg_code = FIFO head when pkg_valid=1, else 0.
  - Once pkg_valid=1, pkg_code stays stable until the transfer (pkg_valid & pkg_ready).
- Transfer: pop the FIFO and increment truck_count.
- FSM:
  - LOAD: a transfer that makes truck_count==TRUCK_CAP moves to DEPART in the next cycle. pkg_valid drops in the same cycle the count hits the cap, so there is no over-issue.
  - DEPART: truck_full=1 and pkg_valid=0. Arbitration and the FIFO keep filling. On truck_depart=1, set truck_count=0 and go to LOAD.
  - truck_depart while in LOAD is ignored.
- Arithmetic: truck_count is 4-bit, saturates at TRUCK_CAP, and never wraps.
- lost bits clear only on reset.

Decomposition:
- Shared package sock_pkg_defs holds:
  - package codes PKG_NONE=0, PKG_ALG_BAJO=1, PKG_POL_BAJO=2, PKG_ACR_BAJO=3, PKG_ALG_ALTO=4, PKG_ACR_ALTO=5;
  - source count NUM_SRC=5;
  - state encodings LOAD=0, DEPART=1.
- One natural sub-module: sock_pkg_fifo, a parameterised synchronous FIFO with push, pop, full, empty and level.

Test Plan:
- Reset, then co=5'b00001 at cycle 1 with pkg_ready=1 -> pkg_valid=1 with pkg_code=1 at cycle 3; truck_count=1 at cycle 4; lost=0.
- co=5'b11111 in one cycle, pkg_ready=1 -> codes issued in order 1,2,3,4,5; the next single co=5'b00001 is granted after rr_ptr wraps.
- pkg_ready=0 and 8 spaced co pulses across all sources -> fifo_level saturates at 4, remaining requests are held pending, and lost bits set only for repeated pulses on a still-pending source.
- TRUCK_CAP=6, 8 packages queued, pkg_ready=1 -> exactly 6 transfers, then truck_full=1 and pkg_valid=0; truck_depart pulse -> truck_count=0 and the remaining 2 packages issue.
- pkg_valid=1 with pkg_ready held 0 for 5 cycles -> pkg_code remains constant; a co pulse arriving meanwhile does not alter pkg_code.
- Reset held low for one cycle with 3 packages queued and truck_count=2 -> all outputs return to their reset values next cycle.
